// File: rtl/blit2d_pkg.sv
// Shared types and reset constants for the 2D rectangle blitter.
// Pixel modes, controller states and the idle/reset values of the bus interface.
package blit2d_pkg;

    typedef enum logic [1:0] {
        MODE_FILL = 2'd0,
        MODE_COPY = 2'd1,
        MODE_KEY  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR_REQ  = 3'd4,
        ST_WR_WAIT = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    localparam state_e RST_STATE = ST_IDLE;
    localparam logic   RST_CTRL  = 1'b0;

endpackage

// File: rtl/rect_walker.sv
// Raster walker: x/y position and per-row base pointers, advanced one pixel at a time.
// Row pointers accumulate the stride so no multiplier is needed.
module rect_walker #(
    parameter int RANGEW = 9,
    parameter int ADDRW  = 18
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init,
    input  logic              advance,
    input  logic [ADDRW-1:0]  src_base,
    input  logic [ADDRW-1:0]  dst_base,
    input  logic [RANGEW:0]   stride,
    input  logic [RANGEW-1:0] width,
    input  logic [RANGEW-1:0] height,
    output logic [ADDRW-1:0]  src_adr,
    output logic [ADDRW-1:0]  dst_adr,
    output logic [ADDRW-1:0]  src_nxt,
    output logic [ADDRW-1:0]  dst_nxt,
    output logic              last
);

    logic [RANGEW-1:0] x_q, y_q;
    logic [ADDRW-1:0]  src_row_q, dst_row_q, stride_a;
    logic              row_end;

    assign stride_a = ADDRW'(stride);
    assign row_end  = (x_q == width - RANGEW'(1));
    assign last     = row_end && (y_q == height - RANGEW'(1));
    assign src_adr  = src_row_q + ADDRW'(x_q);
    assign dst_adr  = dst_row_q + ADDRW'(x_q);
    // Address of the pixel that follows, so a request can issue in the same cycle as the advance.
    assign src_nxt  = row_end ? src_row_q + stride_a : src_adr + ADDRW'(1);
    assign dst_nxt  = row_end ? dst_row_q + stride_a : dst_adr + ADDRW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q       <= '0;
            y_q       <= '0;
            src_row_q <= '0;
            dst_row_q <= '0;
        end else if (init) begin
            x_q       <= '0;
            y_q       <= '0;
            src_row_q <= src_base;
            dst_row_q <= dst_base;
        end else if (advance) begin
            if (row_end) begin
                x_q       <= '0;
                y_q       <= y_q + RANGEW'(1);
                src_row_q <= src_row_q + stride_a;
                dst_row_q <= dst_row_q + stride_a;
            end else begin
                x_q <= x_q + RANGEW'(1);
            end
        end
    end

endmodule

// File: rtl/blit_rect_2d.sv
// 2D rectangle fill/copy/colour-key engine with a single Wishbone-style master port.
// Holds the job registers, controller FSM and bus handshake; rect_walker supplies addresses.
module blit_rect_2d
    import blit2d_pkg::*;
#(
    parameter int COLORW = 16,
    parameter int RANGEW = 9,
    parameter int ADDRW  = 18,
    parameter int SELW   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    input  logic [COLORW-1:0] color_i,
    input  logic [ADDRW-1:0]  src_base_i,
    input  logic [ADDRW-1:0]  dst_base_i,
    input  logic [RANGEW:0]   stride_i,
    input  logic [RANGEW-1:0] width_i,
    input  logic [RANGEW-1:0] height_i,
    input  logic              busy_bus_i,
    input  logic              ack_i,
    input  logic [COLORW-1:0] dat_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDRW-1:0]  adr_o,
    output logic [COLORW-1:0] dat_o,
    output logic [SELW-1:0]   sel_o,
    output logic              busy_o,
    output logic              irq_o,
    input  logic              irq_clr_i,
    output logic              aborted_o
);

    typedef struct packed {
        mode_e             mode;
        logic [COLORW-1:0] color;
        logic [ADDRW-1:0]  src_base;
        logic [ADDRW-1:0]  dst_base;
        logic [RANGEW:0]   stride;
        logic [RANGEW-1:0] width;
        logic [RANGEW-1:0] height;
    } job_t;

    state_e            state_q, state_d;
    job_t              job_q;
    logic [COLORW-1:0] rdata_q, wdata;
    logic              abort_q, abort_pend, is_fill, is_read;
    logic              issue, issue_rd, go_done, abort_done, advance;
    logic [ADDRW-1:0]  issue_adr;
    logic [ADDRW-1:0]  walk_src, walk_dst, walk_src_nxt, walk_dst_nxt;
    logic              walk_last;

    assign busy_o     = (state_q != ST_IDLE);
    assign abort_pend = abort_q | abort_i;
    assign is_fill    = (job_q.mode != MODE_COPY) && (job_q.mode != MODE_KEY);
    assign is_read    = !is_fill;
    assign wdata      = (state_q == ST_WR_REQ && !is_fill) ? rdata_q : job_q.color;
    assign advance    = (state_q == ST_NEXT) && !walk_last && !abort_pend;

    rect_walker #(.RANGEW(RANGEW), .ADDRW(ADDRW)) u_walker (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .init     (state_q == ST_SETUP),
        .advance  (advance),
        .src_base (job_q.src_base),
        .dst_base (job_q.dst_base),
        .stride   (job_q.stride),
        .width    (job_q.width),
        .height   (job_q.height),
        .src_adr  (walk_src),
        .dst_adr  (walk_dst),
        .src_nxt  (walk_src_nxt),
        .dst_nxt  (walk_dst_nxt),
        .last     (walk_last)
    );

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_rd   = 1'b0;
        issue_adr  = walk_dst;
        go_done    = 1'b0;
        abort_done = 1'b0;
        case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_SETUP;
            ST_SETUP: begin
                if (job_q.width == '0 || job_q.height == '0) begin
                    go_done = 1'b1;
                end else if (abort_pend || busy_bus_i) begin
                    state_d = is_read ? ST_RD_REQ : ST_WR_REQ;
                end else begin
                    issue     = 1'b1;
                    issue_rd  = is_read;
                    issue_adr = is_read ? job_q.src_base : job_q.dst_base;
                end
            end
            ST_RD_REQ, ST_WR_REQ: begin
                if (abort_pend) begin
                    go_done    = 1'b1;
                    abort_done = 1'b1;
                end else if (!busy_bus_i) begin
                    issue     = 1'b1;
                    issue_rd  = (state_q == ST_RD_REQ);
                    issue_adr = issue_rd ? walk_src : walk_dst;
                end
            end
            ST_RD_WAIT: begin
                // A keyed pixel equal to the transparent colour is skipped entirely.
                if (ack_i)
                    state_d = (job_q.mode == MODE_KEY && dat_i == job_q.color) ? ST_NEXT : ST_WR_REQ;
            end
            ST_WR_WAIT: if (ack_i) state_d = ST_NEXT;
            ST_NEXT: begin
                if (walk_last || abort_pend) begin
                    go_done    = 1'b1;
                    abort_done = !walk_last;
                end else if (busy_bus_i) begin
                    state_d = is_read ? ST_RD_REQ : ST_WR_REQ;
                end else begin
                    issue     = 1'b1;
                    issue_rd  = is_read;
                    issue_adr = is_read ? walk_src_nxt : walk_dst_nxt;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (issue)   state_d = issue_rd ? ST_RD_WAIT : ST_WR_WAIT;
        if (go_done) state_d = ST_DONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RST_STATE;
            job_q     <= '0;
            rdata_q   <= '0;
            abort_q   <= RST_CTRL;
            cyc_o     <= RST_CTRL;
            stb_o     <= RST_CTRL;
            we_o      <= RST_CTRL;
            adr_o     <= '0;
            dat_o     <= '0;
            sel_o     <= '0;
            irq_o     <= RST_CTRL;
            aborted_o <= RST_CTRL;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start_i) begin
                job_q     <= '{mode: mode_e'(mode_i), color: color_i, src_base: src_base_i,
                               dst_base: dst_base_i, stride: stride_i, width: width_i,
                               height: height_i};
                abort_q   <= 1'b0;
                aborted_o <= 1'b0;
            end else if (busy_o && abort_i) begin
                abort_q <= 1'b1;
            end
            if (abort_done) aborted_o <= 1'b1;

            if (state_q == ST_RD_WAIT && ack_i) rdata_q <= dat_i;

            if (issue) begin
                stb_o <= 1'b1;
                sel_o <= '1;
                we_o  <= !issue_rd;
                adr_o <= issue_adr;
                if (!issue_rd) dat_o <= wdata;
            end else if (stb_o && ack_i) begin
                stb_o <= 1'b0;
                sel_o <= '0;
            end

            // Bus ownership is released while another master holds the bus between transfers.
            if (go_done)                    cyc_o <= 1'b0;
            else if (issue)                 cyc_o <= 1'b1;
            else if (!stb_o && busy_bus_i)  cyc_o <= 1'b0;

            if (go_done)        irq_o <= 1'b1;
            else if (irq_clr_i) irq_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_blit_rect_2d.sv
// Self-checking bench for blit_rect_2d: directed plan cases plus randomized jobs
// compared against a raster-order write list computed from the job description.
module tb_blit_rect_2d;

    localparam int COLORW = 16, RANGEW = 9, ADDRW = 18, SELW = 2;

    logic clk = 1'b0, rst_ni = 1'b1, start_i = 1'b0, abort_i = 1'b0;
    logic busy_bus_i = 1'b0, irq_clr_i = 1'b0, ack_i;
    logic [1:0]        mode_i = '0;
    logic [COLORW-1:0] color_i = '0, dat_i, dat_o;
    logic [ADDRW-1:0]  src_base_i = '0, dst_base_i = '0, adr_o;
    logic [RANGEW:0]   stride_i = '0;
    logic [RANGEW-1:0] width_i = '0, height_i = '0;
    logic cyc_o, stb_o, we_o, busy_o, irq_o, aborted_o;
    logic [SELW-1:0] sel_o;

    int checks = 0, failures = 0;
    int ack_delay = 0, wait_cnt = 0, acks = 0, issues = 0, unstable = 0;
    logic        stb_prev = 1'b0;
    logic [34:0] prev_bus = '0;
    logic [COLORW-1:0] src_mem [0:(1<<ADDRW)-1];
    logic [33:0] wq[$], exp_q[$];

    blit_rect_2d #(.COLORW(COLORW), .RANGEW(RANGEW), .ADDRW(ADDRW), .SELW(SELW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
        .color_i(color_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i), .stride_i(stride_i),
        .width_i(width_i), .height_i(height_i), .busy_bus_i(busy_bus_i), .ack_i(ack_i),
        .dat_i(dat_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .sel_o(sel_o), .busy_o(busy_o), .irq_o(irq_o), .irq_clr_i(irq_clr_i),
        .aborted_o(aborted_o)
    );

    always #5 clk = ~clk;

    // Memory slave: ack after ack_delay wait cycles, reads from src_mem, logs writes.
    assign ack_i = stb_o && (wait_cnt >= ack_delay);
    assign dat_i = src_mem[adr_o];

    always @(posedge clk) begin
        wait_cnt <= (stb_o && !ack_i) ? wait_cnt + 1 : 0;
        if (stb_o && ack_i) acks <= acks + 1;
        if (stb_o && !stb_prev) issues <= issues + 1;
        if (stb_o && stb_prev && {adr_o, dat_o, we_o} != prev_bus) unstable <= unstable + 1;
        if (stb_o && ack_i && we_o) wq.push_back({adr_o, dat_o});
        stb_prev <= stb_o;
        prev_bus <= {adr_o, dat_o, we_o};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] m, input logic [15:0] col, input logic [17:0] s,
                          input logic [17:0] d, input logic [9:0] str, input logic [8:0] w,
                          input logic [8:0] h);
        mode_i = m; color_i = col; src_base_i = s; dst_base_i = d;
        stride_i = str; width_i = w; height_i = h;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Reference: every pixel in raster order, address = base + y*stride + x mod 2^ADDRW.
    task automatic build_model(input logic [1:0] m, input logic [15:0] col, input logic [17:0] s,
                               input logic [17:0] d, input logic [9:0] str, input int w, input int h);
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                logic [17:0] sa, da;
                sa = 18'(s + y * str + x);
                da = 18'(d + y * str + x);
                case (m)
                    2'd1:    exp_q.push_back({da, src_mem[sa]});
                    2'd2:    if (src_mem[sa] != col) exp_q.push_back({da, src_mem[sa]});
                    default: exp_q.push_back({da, col});
                endcase
            end
        end
    endtask

    task automatic preload(input logic [15:0] col, input logic [17:0] s, input logic [9:0] str,
                           input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                src_mem[18'(s + y * str + x)] = ($urandom_range(0, 2) == 0) ? col : 16'($urandom);
    endtask

    task automatic wait_done(input int limit, inout int c);
        while (!irq_o && c < limit) begin
            tick();
            c++;
        end
        check("irq_done", irq_o, 1'b1);
    endtask

    task automatic compare_writes(input string tag, input int n);
        check({tag, "_nwr"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wq[i], exp_q[i]);
    endtask

    task automatic clear_irq();
        irq_clr_i = 1'b1;
        tick();
        irq_clr_i = 1'b0;
        check("irq_clr", irq_o, 1'b0);
    endtask

    task automatic run_job(input string tag, input logic [1:0] m, input logic [15:0] col,
                           input logic [17:0] s, input logic [17:0] d, input logic [9:0] str,
                           input int w, input int h, input int dly, input bit pre);
        int c, a0, nacks;
        if (pre) preload(col, s, str, w, h);
        build_model(m, col, s, d, str, w, h);
        ack_delay = dly;
        wq.delete();
        a0 = acks;
        launch(m, col, s, d, str, 9'(w), 9'(h));
        check({tag, "_abclr"}, aborted_o, 1'b0);
        // A second start and changed inputs while busy must not disturb the job.
        start_i = 1'b1; width_i = 9'd1; dst_base_i = 18'h155; color_i = ~col;
        tick();
        start_i = 1'b0;
        c = 1;
        wait_done(3000, c);
        compare_writes(tag, exp_q.size());
        case (m)
            2'd1:    nacks = 2 * w * h;
            2'd2:    nacks = w * h + exp_q.size();
            default: nacks = w * h;
        endcase
        check({tag, "_acks"}, acks - a0, nacks);
        check({tag, "_stable"}, unstable, 0);
        clear_irq();
        ack_delay = 0;
    endtask

    initial begin
        int c, a0, i0;
        bit any_stb;

        // Reset state
        #2 rst_ni = 1'b0;
        tick(); tick();
        check("rst_ctrl", {cyc_o, stb_o, we_o, busy_o, irq_o, aborted_o}, 6'b0);
        check("rst_adr", adr_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_sel", sel_o, 0);
        rst_ni = 1'b1;
        tick();

        // FILL dst 100 stride 10 3x2: latency, throughput and write list
        build_model(2'd0, 16'hF800, 18'd0, 18'd100, 10'd10, 3, 2);
        wq.delete(); a0 = acks;
        launch(2'd0, 16'hF800, 18'd0, 18'd100, 10'd10, 9'd3, 9'd2);
        check("fill_busy", busy_o, 1'b1);
        check("fill_nostb_n1", {cyc_o, stb_o}, 2'b00);
        color_i = 16'h0000;
        tick(); c = 1;
        check("fill_first_req", {cyc_o, stb_o, we_o, sel_o}, 5'b11111);
        check("fill_first_adr", adr_o, 100);
        check("fill_first_dat", dat_o, 16'hF800);
        wait_done(3000, c);
        check("fill_rate", c <= 2 * 6 + 1, 1'b1);
        compare_writes("fill", 6);
        check("fill_last_const", wq.size() > 0 ? wq[wq.size()-1] : 34'h0, {18'd112, 16'hF800});
        check("fill_acks", acks - a0, 6);
        check("fill_aborted", aborted_o, 1'b0);
        clear_irq();
        check("fill_idle", busy_o, 1'b0);

        // COPY plan case
        src_mem[0] = 16'h000A; src_mem[1] = 16'h000B; src_mem[320] = 16'h000C; src_mem[321] = 16'h000D;
        run_job("copy", 2'd1, 16'h0, 18'd0, 18'd500, 10'd320, 2, 2, 0, 1'b0);
        check("copy_const0", wq.size() > 0 ? wq[0] : 34'h0, {18'd500, 16'h000A});
        check("copy_const3", wq.size() > 3 ? wq[3] : 34'h0, {18'd821, 16'h000D});

        // KEY plan case: key 0x0000, source {0x0000, 0x1234}
        src_mem[1000] = 16'h0000; src_mem[1001] = 16'h1234;
        run_job("key", 2'd2, 16'h0000, 18'd1000, 18'd2000, 10'd10, 2, 1, 0, 1'b0);
        check("key_const", wq.size() == 1 ? wq[0] : 34'h0, {18'd2001, 16'h1234});

        // Zero width, with irq clear held high so set must win
        i0 = issues;
        irq_clr_i = 1'b1;
        launch(2'd0, 16'h1111, 18'd0, 18'd50, 10'd10, 9'd0, 9'd3);
        check("zw_irq_early", irq_o, 1'b0);
        tick();
        check("zw_irq", irq_o, 1'b1);
        irq_clr_i = 1'b0;
        tick(); tick();
        check("zw_nostb", issues - i0, 0);
        check("zw_idle", busy_o, 1'b0);
        clear_irq();

        // Zero height
        i0 = issues;
        launch(2'd1, 16'h2222, 18'd0, 18'd60, 10'd10, 9'd4, 9'd0);
        tick();
        check("zh_irq", irq_o, 1'b1);
        tick(); tick();
        check("zh_nostb", issues - i0, 0);
        clear_irq();

        // busy_bus_i held 5 cycles at the first request
        build_model(2'd0, 16'h5A5A, 18'd0, 18'd700, 10'd5, 2, 2);
        wq.delete();
        busy_bus_i = 1'b1;
        any_stb = 1'b0;
        launch(2'd0, 16'h5A5A, 18'd0, 18'd700, 10'd5, 9'd2, 9'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            any_stb = any_stb | stb_o | cyc_o;
        end
        check("bb_blocked", any_stb, 1'b0);
        busy_bus_i = 1'b0;
        c = 0;
        wait_done(3000, c);
        compare_writes("bb", 4);
        clear_irq();

        // 3-cycle ack delay
        run_job("dly3", 2'd1, 16'h0, 18'd1500, 18'd9000, 10'd7, 3, 2, 3, 1'b1);

        // Abort mid-job: completes the in-flight transfer, prefix of the full write list
        build_model(2'd0, 16'hBEEF, 18'd0, 18'd3000, 10'd16, 10, 10);
        wq.delete(); a0 = acks; i0 = issues;
        ack_delay = 2;
        launch(2'd0, 16'hBEEF, 18'd0, 18'd3000, 10'd16, 9'd10, 9'd10);
        for (int k = 0; k < 8; k++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        c = 0;
        wait_done(3000, c);
        check("abort_flag", aborted_o, 1'b1);
        check("abort_short", wq.size() > 0 && wq.size() < 100, 1'b1);
        compare_writes("abort", wq.size());
        check("abort_nocut", acks - a0, issues - i0);
        check("abort_stable", unstable, 0);
        clear_irq();
        ack_delay = 0;

        // Asynchronous reset mid-job
        ack_delay = 3;
        launch(2'd0, 16'h7777, 18'd0, 18'd5000, 10'd8, 9'd8, 9'd8);
        tick(); tick(); tick();
        check("arst_running", busy_o, 1'b1);
        #3 rst_ni = 1'b0;
        #1;
        check("arst_ctrl", {cyc_o, stb_o, we_o, busy_o, irq_o, aborted_o}, 6'b0);
        check("arst_bus", {adr_o, dat_o, sel_o}, 36'h0);
        tick();
        rst_ni = 1'b1;
        ack_delay = 0;
        tick();
        check("arst_noirq", irq_o, 1'b0);
        run_job("post_rst", 2'd0, 16'h3C3C, 18'd0, 18'd6000, 10'd20, 4, 3, 0, 1'b0);

        // Randomized jobs, including mode 3 and destination address wrap
        for (int n = 0; n < 10; n++) begin
            logic [1:0]  m;
            logic [17:0] s, d;
            logic [15:0] col;
            int w, h, str;
            m   = 2'($urandom_range(0, 3));
            w   = $urandom_range(1, 5);
            h   = $urandom_range(1, 4);
            str = $urandom_range(1, 40);
            s   = 18'($urandom_range(0, 2000));
            d   = (n % 3 == 0) ? 18'(18'h3FFF0 + $urandom_range(0, 8)) : 18'($urandom_range(10000, 20000));
            col = 16'($urandom);
            run_job($sformatf("rnd%0d", n), m, col, s, d, 10'(str), w, h,
                    $urandom_range(0, 2), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
